// File: rtl/imem_loader.sv
// Instruction-memory loader: streams a program into local storage, then serves zero-latency fetches.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (additive 32-bit checksum of loaded words).
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic [31:0]       raddr,
  output logic [DATA_W-1:0] instr,
  output logic              run,
  output logic              err,
  output logic [ADDR_W:0]   count,
  output logic [31:0]       checksum
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              fire;
  logic [ADDR_W-1:0] rd_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  assign fire   = load_valid & load_ready;
  assign rd_idx = raddr[ADDR_W-1:0];

  // State register with the handshake and status flags registered alongside it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      load_ready <= 1'b1;
      run        <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= next_state;
      load_ready <= (next_state == LOAD);
      run        <= (next_state == RUN);
      err        <= (next_state == ERR);
    end
  end

  // Next-state logic; last always wins, even on the final free slot.
  always_comb begin
    next_state = state;
    case (state)
      LOAD: begin
        if (fire && load_last) begin
          next_state = RUN;
        end else if (fire && (count == LAST_CNT)) begin
          next_state = ERR;
        end else begin
          next_state = LOAD;
        end
      end
      RUN:     next_state = RUN;
      ERR:     next_state = ERR;
      default: next_state = LOAD;
    endcase
  end

  // Word counter; doubles as the write pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= {(ADDR_W+1){1'b0}};
    end else if (fire) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

  // Program storage has no reset so a reset keeps stale contents; writes are gated by reset level.
  always_ff @(posedge clock) begin
    if (fire && !reset) begin
      mem[count[ADDR_W-1:0]] <= load_data;
    end
  end

  // Fetch path: only words below count are visible, so unwritten storage never leaks out.
  always_comb begin
    instr = {DATA_W{1'b0}};
    if (run && !reset && ((raddr >> ADDR_W) == 32'd0) && ({1'b0, rd_idx} < count)) begin
      instr = mem[rd_idx];
    end else begin
      instr = {DATA_W{1'b0}};
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] data_word;
  assign data_word = 32'(load_data);

  // Running modulo-2^32 sum of accepted words; frozen once loading ends.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      checksum <= 32'd0;
    end else if (fire) begin
      checksum <= checksum + data_word;
    end else begin
      checksum <= checksum;
    end
  end
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: vector tables plus hand-written multi-cycle sequences.
module tb_imem_loader;

  logic        clock;
  logic        reset;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic [31:0] raddr;
  logic [31:0] instr;
  logic        run;
  logic        err;
  logic [6:0]  count;
  logic [31:0] checksum;

  int n_checks;
  int n_pass;

  typedef struct {
    logic [31:0] raddr;
    logic [31:0] exp_instr;
  } rd_vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic [6:0]  exp_count;
    logic        exp_ready;
  } ld_vec_t;

  rd_vec_t rd_tbl[8];
  int      n_rd;
  ld_vec_t ld_tbl[4];

  imem_loader #(.ADDR_W(6), .DATA_W(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_last  (load_last),
    .raddr      (raddr),
    .instr      (instr),
    .run        (run),
    .err        (err),
    .count      (count),
    .checksum   (checksum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    load_valid = 1'b0;
    load_last = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Presents one word at a negedge, lets one rising edge pass, returns at the following negedge.
  task automatic send_word(input logic [31:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    @(posedge clock);
    @(negedge clock);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic apply_rd_tbl(input string tag);
    for (int i = 0; i < n_rd; i++) begin
      raddr = rd_tbl[i].raddr;
      #1;
      check($sformatf("%s_rd%0d", tag, i), instr, rd_tbl[i].exp_instr);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = 32'd0;
    load_last  = 1'b0;
    raddr      = 32'd0;

    // Reset state
    #3;
    check("rst_ready", load_ready, 1);
    check("rst_run", run, 0);
    check("rst_err", err, 0);
    check("rst_count", count, 0);
    check("rst_checksum", checksum, 0);
    check("rst_instr", instr, 0);
    @(negedge clock);
    reset = 1'b0;

    // Three-word program, last on the third
    send_word(32'h2001_0005, 1'b0);
    raddr = 32'd0;
    #1;
    check("load_instr_zero", instr, 0);
    check("load_ready_mid", load_ready, 1);
    send_word(32'h2002_0007, 1'b0);
    send_word(32'h0000_000D, 1'b1);
    check("p3_ready", load_ready, 0);
    check("p3_run", run, 1);
    check("p3_err", err, 0);
    check("p3_count", count, 3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("p3_checksum", checksum, 64'h4003_0019);
`else
    check("p3_checksum", checksum, 0);
`endif
    rd_tbl[0] = '{32'd0,         32'h2001_0005};
    rd_tbl[1] = '{32'd1,         32'h2002_0007};
    rd_tbl[2] = '{32'd2,         32'h0000_000D};
    rd_tbl[3] = '{32'd3,         32'h0000_0000};
    rd_tbl[4] = '{32'd63,        32'h0000_0000};
    rd_tbl[5] = '{32'h0000_0041, 32'h0000_0000};
    rd_tbl[6] = '{32'h8000_0001, 32'h0000_0000};
    n_rd = 7;
    apply_rd_tbl("p3");

    // Loader traffic in RUN is ignored
    @(negedge clock);
    send_word(32'hDEAD_BEEF, 1'b0);
    check("run_ign_count", count, 3);
    raddr = 32'd2;
    #1;
    check("run_ign_mem", instr, 32'h0000_000D);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("run_hold_checksum", checksum, 64'h4003_0019);
`else
    check("run_hold_checksum", checksum, 0);
`endif

    // Asynchronous reset from RUN
    #1;
    reset = 1'b1;
    #1;
    check("async_run", run, 0);
    check("async_count", count, 0);
    check("async_instr", instr, 0);
    check("async_ready", load_ready, 1);
    @(negedge clock);
    reset = 1'b0;

    // Toggled valid: data/last while valid=0 must be ignored
    ld_tbl[0] = '{1'b1, 32'h0000_000A, 1'b0, 7'd1, 1'b1};
    ld_tbl[1] = '{1'b0, 32'h0000_0BAD, 1'b1, 7'd1, 1'b1};
    ld_tbl[2] = '{1'b1, 32'h0000_000B, 1'b1, 7'd2, 1'b0};
    ld_tbl[3] = '{1'b0, 32'h0000_0C0D, 1'b0, 7'd2, 1'b0};
    for (int i = 0; i < 4; i++) begin
      load_valid = ld_tbl[i].valid;
      load_data  = ld_tbl[i].data;
      load_last  = ld_tbl[i].last;
      @(posedge clock);
      @(negedge clock);
      check($sformatf("tog_count%0d", i), count, ld_tbl[i].exp_count);
      check($sformatf("tog_ready%0d", i), load_ready, ld_tbl[i].exp_ready);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check("tog_run", run, 1);
    rd_tbl[0] = '{32'd0, 32'h0000_000A};
    rd_tbl[1] = '{32'd1, 32'h0000_000B};
    rd_tbl[2] = '{32'd2, 32'h0000_0000};
    n_rd = 3;
    apply_rd_tbl("tog");

    // Overflow: 64 words, no last
    do_reset();
    for (int i = 0; i < 63; i++) send_word(32'h0000_1000 + 32'(i), 1'b0);
    check("ovf_count63", count, 63);
    check("ovf_ready63", load_ready, 1);
    check("ovf_err63", err, 0);
    send_word(32'h0000_103F, 1'b0);
    check("ovf_err", err, 1);
    check("ovf_run", run, 0);
    check("ovf_count", count, 64);
    check("ovf_ready", load_ready, 0);
    for (int a = 0; a < 65; a++) begin
      raddr = 32'(a);
      #1;
      check($sformatf("ovf_instr%0d", a), instr, 0);
    end
    @(negedge clock);
    send_word(32'h0000_BEEF, 1'b1);
    check("err_ign_count", count, 64);
    check("err_stays", err, 1);

    // Full program, last on the 64th word
    do_reset();
    for (int i = 0; i < 63; i++) send_word(32'h0000_3000 + 32'(i), 1'b0);
    send_word(32'hCAFE_F00D, 1'b1);
    check("full_run", run, 1);
    check("full_err", err, 0);
    check("full_count", count, 64);
    check("full_ready", load_ready, 0);
    rd_tbl[0] = '{32'd63, 32'hCAFE_F00D};
    rd_tbl[1] = '{32'd0,  32'h0000_3000};
    rd_tbl[2] = '{32'd62, 32'h0000_303E};
    rd_tbl[3] = '{32'd64, 32'h0000_0000};
    n_rd = 4;
    apply_rd_tbl("full");

    // Reset mid-load discards progress but keeps stale memory hidden
    do_reset();
    for (int i = 0; i < 5; i++) send_word(32'h0000_0500 + 32'(i), 1'b0);
    check("mid_count5", count, 5);
    #2;
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = 32'h0000_0BAD;
    #1;
    check("mid_async_count", count, 0);
    @(posedge clock);
    @(negedge clock);
    check("mid_drop_count", count, 0);
    reset      = 1'b0;
    load_valid = 1'b0;
    send_word(32'h0000_0077, 1'b0);
    send_word(32'h0000_0088, 1'b1);
    check("mid_count", count, 2);
    check("mid_run", run, 1);
    rd_tbl[0] = '{32'd0, 32'h0000_0077};
    rd_tbl[1] = '{32'd1, 32'h0000_0088};
    rd_tbl[2] = '{32'd4, 32'h0000_0000};
    n_rd = 3;
    apply_rd_tbl("mid");

    // Checksum wraps modulo 2^32
    do_reset();
    send_word(32'hFFFF_FFFF, 1'b0);
    send_word(32'h0000_0002, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("cks_wrap", checksum, 1);
`else
    check("cks_wrap", checksum, 0);
`endif
    check("cks_count", count, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 6, meaning log2 of instruction-word depth (DEPTH = 2^ADDR_W).
REQ-002 The module SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-003 The module SHALL use one clock and an asynchronous, active-high reset.
REQ-004 The port list SHALL be:
- `clock`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load_valid`  in  1  loader word available.
- `load_ready`  out  1  block accepts loader word.
- `load_data`  in  DATA_W  instruction word being loaded.
- `load_last`  in  1  qualifies final word of program.
- `raddr`  in  32  word address from the core's fetch port; only [ADDR_W-1:0] indexes; upper bits checked.
- `instr`  out  DATA_W  instruction returned to the core.
- `run`  out  1  program loaded; core may execute.
- `err`  out  1  load overflow.
- `count`  out  ADDR_W+1  number of words loaded.
- `checksum`  out  32  additive checksum of loaded words.

Function
REQ-005 The FSM SHALL have three states, LOAD, RUN and ERR; reset enters LOAD.
REQ-006 A load transfer SHALL occur on a rising edge where load_valid and load_ready are both 1.
REQ-007 load_ready SHALL be 1 in LOAD and 0 in RUN and ERR.
REQ-008 Each transfer SHALL write load_data to mem[count[ADDR_W-1:0]] and increment count by 1.
REQ-009 A transfer with load_last=1 SHALL move the FSM LOAD->RUN on the same edge, whatever the value of count.
REQ-010 A transfer with load_last=0 at count=DEPTH-1 SHALL store the word, set count to DEPTH and move the FSM LOAD->ERR.
REQ-011 load_data and load_last SHALL be ignored when load_valid=0; load_valid SHALL be ignored outside LOAD.
REQ-012 instr SHALL be combinational from raddr (zero latency), because the core samples it in the same cycle.
- In RUN: instr = mem[raddr[ADDR_W-1:0]] when raddr < count; otherwise 0 (NOP).
- In LOAD and ERR: instr = 0.
REQ-013 raddr bits above ADDR_W-1 SHALL force instr=0.
REQ-014 run SHALL be 1 only in RUN; err SHALL be 1 only in ERR; both SHALL be registered outputs of the FSM.
REQ-015 RUN and ERR SHALL be exited only by reset.
REQ-016 Memory contents SHALL be uninitialised storage; no read of an unwritten word SHALL reach instr (guaranteed by REQ-012).

Reset
REQ-017 Reset assertion SHALL immediately, asynchronously, set state=LOAD, count=0, checksum=0, run=0 and err=0.
REQ-018 Reset SHALL leave memory contents unchanged.
REQ-019 A reset during LOAD SHALL discard progress; the next transfer SHALL write address 0.
REQ-020 A transfer coincident with reset assertion SHALL be dropped.
REQ-021 instr SHALL be 0 while reset is asserted.

Configuration
REQ-022 The macro IMEM_LOADER_CHECKSUM_EN SHALL control the checksum feature.
REQ-023 With IMEM_LOADER_CHECKSUM_EN defined, checksum SHALL accumulate checksum <= checksum + load_data[31:0] on every transfer, mod 2^32, and SHALL hold its value in RUN and ERR.
REQ-024 Without IMEM_LOADER_CHECKSUM_EN, checksum SHALL be constant 0 and no adder SHALL be synthesised; the port SHALL remain present.

Verification
REQ-025 Load 3 words 0x20010005, 0x20020007, 0x0000000D with last on the third -> load_ready drops the next cycle, run=1, count=3, instr at raddr=1 is 0x20020007, instr at raddr=3 is 0.
REQ-026 Toggle load_valid 1,0,1,0 with words 0xA, 0xB, last on 0xB -> exactly 2 writes, count=2, mem[0]=0xA, mem[1]=0xB.
REQ-027 Send 64 words with load_last never set -> after the 64th word err=1, run=0, count=64, load_ready=0, instr=0 for all raddr.
REQ-028 Send 64 words with last on the 64th -> run=1, err=0, count=64, raddr=63 returns the 64th word.
REQ-029 Assert reset mid-load after 5 words, then load 2 words with last -> count=2, run=1, and raddr=4 returns 0 despite stale memory.
REQ-030 With IMEM_LOADER_CHECKSUM_EN defined, load 0xFFFFFFFF then 0x00000002 (last) -> checksum=0x00000001; without the macro -> checksum=0.
